// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: bus request/response structs,
// arbiter state encoding and default configuration constants.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arb_state_t;

    localparam int MAX_D_STREAK_DEF = 4;
    localparam int STAT_W_DEF       = 32;

    // Fetch returns one 32-bit word out of the 64-bit memory beat.
    function automatic logic [31:0] word_sel(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_stats.sv
// Grant and fetch-wait counters for the memory-port arbiter.
// Only present when ARB_STATS_EN is defined; counters are read hierarchically.
`ifdef ARB_STATS_EN
module arb_stats #(
    parameter int STAT_W = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_i,
    input  logic grant_d,
    input  logic i_waiting
);

    logic [STAT_W-1:0] i_grants;
    logic [STAT_W-1:0] d_grants;
    logic [STAT_W-1:0] i_wait_cycles;

    // free-running counters, wrapping naturally at 2^STAT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_grants      <= {STAT_W{1'b0}};
            d_grants      <= {STAT_W{1'b0}};
            i_wait_cycles <= {STAT_W{1'b0}};
        end else begin
            i_grants      <= i_grants + STAT_W'(grant_i);
            d_grants      <= d_grants + STAT_W'(grant_d);
            i_wait_cycles <= i_wait_cycles + STAT_W'(i_waiting);
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (ibus) and load/store (dbus), dbus preferred
// with a streak limit. Define ARB_STATS_EN to add the arb_stats grant/wait counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
`ifdef ARB_STATS_EN
    , parameter int STAT_W = STAT_W_DEF
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp
);

    localparam int            SW    = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

    arb_state_t    state_r;
    arb_state_t    state_nx_s;
    logic [SW-1:0] streak_r;
    logic [SW-1:0] streak_nx_s;
    logic          i_hi_r;
    logic          grant_i_s;

    assign grant_i_s = (state_r == IDLE) && (state_nx_s == I_ADDR);

    // state, streak and the half-word select of the granted fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            streak_r <= {SW{1'b0}};
            i_hi_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            streak_r <= streak_nx_s;
            if (grant_i_s) begin
                i_hi_r <= ireq.addr[2];
            end else begin
                i_hi_r <= i_hi_r;
            end
        end
    end

    // arbitration and transaction sequencing
    always_comb begin
        state_nx_s  = state_r;
        streak_nx_s = streak_r;
        case (state_r)
            IDLE: begin
                if (dreq.valid && (!ireq.valid || (streak_r < MAX_S))) begin
                    state_nx_s = D_ADDR;
                    if (ireq.valid) begin
                        streak_nx_s = (streak_r == MAX_S) ? streak_r : streak_r + SW'(1);
                    end else begin
                        streak_nx_s = {SW{1'b0}};
                    end
                end else if (ireq.valid) begin
                    state_nx_s  = I_ADDR;
                    streak_nx_s = {SW{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            I_ADDR: begin
                if (!ireq.valid) begin
                    state_nx_s = IDLE;
                end else if (oresp.addr_ok) begin
                    state_nx_s = oresp.data_ok ? IDLE : I_DATA;
                end else begin
                    state_nx_s = I_ADDR;
                end
            end
            I_DATA: begin
                state_nx_s = oresp.data_ok ? IDLE : I_DATA;
            end
            D_ADDR: begin
                if (!dreq.valid) begin
                    state_nx_s = IDLE;
                end else if (oresp.addr_ok) begin
                    state_nx_s = oresp.data_ok ? IDLE : D_DATA;
                end else begin
                    state_nx_s = D_ADDR;
                end
            end
            D_DATA: begin
                state_nx_s = oresp.data_ok ? IDLE : D_DATA;
            end
            default: begin
                state_nx_s  = IDLE;
                streak_nx_s = {SW{1'b0}};
            end
        endcase
    end

    // forward only the granted port; once past addr_ok, requester valid no longer matters
    always_comb begin
        oreq  = '0;
        iresp = '0;
        dresp = '0;
        case (state_r)
            I_ADDR: begin
                if (ireq.valid) begin
                    oreq.valid    = 1'b1;
                    oreq.addr     = ireq.addr;
                    oreq.size     = MSIZE4;
                    oreq.strobe   = 8'h00;
                    oreq.data     = 64'h0;
                    iresp.addr_ok = oresp.addr_ok;
                    iresp.data_ok = oresp.addr_ok & oresp.data_ok;
                    iresp.data    = (oresp.addr_ok & oresp.data_ok) ?
                                    word_sel(oresp.data, i_hi_r) : 32'h0;
                end else begin
                    oreq = '0;
                end
            end
            I_DATA: begin
                iresp.data_ok = oresp.data_ok;
                iresp.data    = oresp.data_ok ? word_sel(oresp.data, i_hi_r) : 32'h0;
            end
            D_ADDR: begin
                if (dreq.valid) begin
                    oreq          = dreq;
                    dresp.addr_ok = oresp.addr_ok;
                    dresp.data_ok = oresp.addr_ok & oresp.data_ok;
                    dresp.data    = (oresp.addr_ok & oresp.data_ok) ? oresp.data : 64'h0;
                end else begin
                    oreq = '0;
                end
            end
            D_DATA: begin
                dresp.data_ok = oresp.data_ok;
                dresp.data    = oresp.data_ok ? oresp.data : 64'h0;
            end
            IDLE: begin
                oreq = '0;
            end
            default: begin
                oreq = '0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    logic grant_d_s;
    logic i_waiting_s;

    assign grant_d_s   = (state_r == IDLE) && (state_nx_s == D_ADDR);
    assign i_waiting_s = ireq.valid && !grant_i_s && (state_r != I_ADDR) && (state_r != I_DATA);

    arb_stats #(.STAT_W(STAT_W)) u_stats (
        .clk       (clk),
        .reset     (reset),
        .grant_i   (grant_i_s),
        .grant_d   (grant_d_s),
        .i_waiting (i_waiting_s)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: a transaction-level model plays
// both requesters and the memory side and predicts every output each cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAXS = 4;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  oreq;
    dbus_resp_t oresp;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // requester stimulus and transaction-level model of the shared port
    ibus_req_t   im;
    dbus_req_t   dm;
    bit          busy, who_d, acc, d_same, lat_hi, prev_ov;
    int          a_wait, d_wait, streak;
    int          cnt_ig, cnt_dg, cnt_iw;
    int          raise_i, raise_d, bud_i, bud_d;
    int          f_a, f_ds, f_dw;
    bit          fix_en;
    logic [63:0] fix_data, mdata;
    bit          obs[$];
    ibus_resp_t  smp_iresp;
    dbus_resp_t  smp_dresp;
    dbus_req_t   smp_oreq;

    function automatic ibus_req_t new_i();
        ibus_req_t r;
        r.valid = 1'b1;
        r.addr  = {32'h0, 4'h8, 26'($urandom), 2'b00};
        return r;
    endfunction

    function automatic dbus_req_t new_d();
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = {32'h0, 4'h1, 28'($urandom)};
        r.size   = msize_t'(3'($urandom_range(0, 3)));
        r.strobe = 8'($urandom);
        r.data   = {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [15:0] pack_obs();
        logic [15:0] v = 16'h0;
        for (int k = 0; k < obs.size() && k < 16; k++) v[k] = obs[k];
        return v;
    endfunction

    task automatic plan();
        a_wait = (f_a  >= 0) ? f_a  : int'($urandom_range(0, 2));
        d_same = (f_ds >= 0) ? f_ds[0] : 1'($urandom);
        d_wait = (f_dw >= 0) ? f_dw : int'($urandom_range(0, 2));
    endtask

    task automatic step();
        bit         gvalid, hs_i, hs_d, gi, gd, i_owned;
        ibus_resp_t ei;
        dbus_resp_t ed;
        dbus_req_t  eo;
        @(negedge clk);
        ireq  = im;
        dreq  = dm;
        mdata = fix_en ? fix_data : {$urandom, $urandom};
        oresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: mdata};
        ei = '0; ed = '0; eo = '0;
        gvalid = who_d ? dm.valid : im.valid;
        if (busy) begin
            if (!acc) begin
                if (gvalid) begin
                    eo = who_d ? dm : '{valid: 1'b1, addr: im.addr, size: MSIZE4,
                                       strobe: 8'h00, data: 64'h0};
                    if (a_wait == 0) begin
                        oresp.addr_ok = 1'b1;
                        oresp.data_ok = d_same;
                    end
                end
            end else if (d_wait == 0) begin
                oresp.data_ok = 1'b1;
            end
            if (who_d) begin
                ed.addr_ok = oresp.addr_ok;
                ed.data_ok = oresp.data_ok;
                ed.data    = oresp.data_ok ? mdata : 64'h0;
            end else begin
                ei.addr_ok = oresp.addr_ok;
                ei.data_ok = oresp.data_ok;
                ei.data    = oresp.data_ok ? (lat_hi ? mdata[63:32] : mdata[31:0]) : 32'h0;
            end
        end
        #1;
        smp_iresp = iresp;
        smp_dresp = dresp;
        smp_oreq  = oreq;
        check_eq("oreq", 192'(oreq), 192'(eo));
        check_eq("iresp", 192'(iresp), 192'(ei));
        check_eq("dresp", 192'(dresp), 192'(ed));
        check_eq("streak", 192'(dut.streak_r), 192'(streak));
        if (oreq.valid && !prev_ov) obs.push_back(oreq.addr[31:28] == 4'h1);
        prev_ov = oreq.valid;

        @(posedge clk);
        hs_i    = busy && !who_d && !acc && im.valid && (a_wait == 0);
        hs_d    = busy &&  who_d && !acc && dm.valid && (a_wait == 0);
        i_owned = busy && !who_d;
        gi = 1'b0;
        gd = 1'b0;
        if (!busy) begin
            if (dm.valid && (!im.valid || streak < MAXS)) begin
                gd     = 1'b1;
                streak = im.valid ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            end else if (im.valid) begin
                gi     = 1'b1;
                streak = 0;
            end
            if (gi || gd) begin
                busy   = 1'b1;
                who_d  = gd;
                acc    = 1'b0;
                lat_hi = im.addr[2];
                plan();
            end
        end else if (!acc) begin
            if (!gvalid) busy = 1'b0;
            else if (a_wait == 0) begin
                if (d_same) busy = 1'b0;
                else acc = 1'b1;
            end else a_wait--;
        end else begin
            if (d_wait == 0) busy = 1'b0;
            else d_wait--;
        end
        if (im.valid && !gi && !i_owned) cnt_iw++;
        if (gi) cnt_ig++;
        if (gd) cnt_dg++;
        if (hs_i) im.valid = 1'b0;
        if (hs_d) dm.valid = 1'b0;
        if (!im.valid && bud_i > 0 && $urandom_range(0, 99) < raise_i) begin
            im = new_i();
            bud_i--;
        end
        if (!dm.valid && bud_d > 0 && $urandom_range(0, 99) < raise_d) begin
            dm = new_d();
            bud_d--;
        end
    endtask

    task automatic model_reset();
        busy = 1'b0; acc = 1'b0; who_d = 1'b0; streak = 0; prev_ov = 1'b0;
        cnt_ig = 0; cnt_dg = 0; cnt_iw = 0;
        obs.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        im = '0; dm = '0;
        ireq = '0; dreq = '0; oresp = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic unforce_plan();
        f_a = -1; f_ds = -1; f_dw = -1; fix_en = 1'b0;
    endtask

    initial begin
        bit done;
        unforce_plan();
        fix_data = 64'h1111_2222_3333_4444;
        raise_i = 0; raise_d = 0; bud_i = 0; bud_d = 0;
        do_reset();
        #1;
        check_eq("rst_oreq", 192'(oreq), 192'(0));
        check_eq("rst_iresp", 192'(iresp), 192'(0));
        check_eq("rst_dresp", 192'(dresp), 192'(0));
        check_eq("rst_state", 192'(dut.state_r), 192'(IDLE));

        // fetch only, accepted with data on the second address cycle
        fix_en = 1'b1; f_a = 1; f_ds = 1;
        im = '{valid: 1'b1, addr: 64'h8000_0004};
        repeat (3) step();
        check_eq("t1_iresp", 192'(smp_iresp), 192'({1'b1, 1'b1, 32'h1111_2222}));
        check_eq("t1_dresp", 192'(smp_dresp), 192'(0));
        repeat (2) step();

        // simultaneous requests: D first, I after the bubble
        obs.delete(); prev_ov = 1'b0;
        f_a = 0; f_ds = 1;
        im = new_i(); dm = new_d();
        repeat (3) step();
        check_eq("t2_bubble", 192'(smp_oreq.valid), 192'(0));
        step();
        check_eq("t2_i_grant", 192'({smp_oreq.valid, smp_oreq.addr[31:28]}), 192'({1'b1, 4'h8}));
        repeat (2) step();
        check_eq("t2_count", 192'(obs.size()), 192'(2));
        check_eq("t2_order", 192'(pack_obs()), 192'(16'h0001));

        // address accepted, data three cycles later
        f_a = 0; f_ds = 0; f_dw = 2;
        dm = new_d();
        repeat (2) step();
        check_eq("t4_addr_ok", 192'(smp_dresp), 192'({1'b1, 1'b0, 64'h0}));
        step();
        check_eq("t4_wait", 192'({smp_oreq.valid, smp_dresp}), 192'(0));
        repeat (2) step();
        check_eq("t4_data_ok", 192'(smp_dresp), 192'({1'b0, 1'b1, 64'h1111_2222_3333_4444}));
        repeat (2) step();

        // fetch valid withdrawn before address acceptance
        unforce_plan();
        f_a = 2;
        im = new_i();
        step();
        im.valid = 1'b0;
        step();
        check_eq("t6_drop", 192'(smp_oreq), 192'(0));
        repeat (2) step();

        // streak limit under sustained dbus traffic
        unforce_plan();
        do_reset();
        im = new_i(); dm = new_d();
        bud_d = 5; raise_d = 100;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            step();
            done = (cnt_dg == 6) && !busy && !dm.valid;
        end
        check_eq("t3_done", 192'(done), 192'(1));
        check_eq("t3_count", 192'(obs.size()), 192'(7));
        check_eq("t3_order", 192'(pack_obs()), 192'(16'h006F));
`ifdef ARB_STATS_EN
        check_eq("t3_d_grants", 192'(dut.u_stats.d_grants), 192'(6));
        check_eq("t3_i_grants", 192'(dut.u_stats.i_grants), 192'(1));
        check_eq("t3_i_wait", 192'(dut.u_stats.i_wait_cycles), 192'(cnt_iw));
`endif
        raise_d = 0; bud_d = 0;

        // reset in the middle of a D data phase
        f_a = 0; f_ds = 0; f_dw = 5;
        dm = new_d();
        repeat (3) step();
        @(negedge clk);
        im = new_i(); dm = '0;
        ireq = im; dreq = dm; oresp = '0;
        reset = 1'b1;
        #1;
        check_eq("t5_oreq", 192'(oreq), 192'(0));
        check_eq("t5_iresp", 192'(iresp), 192'(0));
        check_eq("t5_dresp", 192'(dresp), 192'(0));
        check_eq("t5_state", 192'(dut.state_r), 192'(IDLE));
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        unforce_plan();
        repeat (6) step();
        check_eq("t5_count", 192'(obs.size()), 192'(1));
        check_eq("t5_first_i", 192'(pack_obs()), 192'(0));

        // random traffic on both ports
        raise_i = 40; raise_d = 60; bud_i = 100000; bud_d = 100000;
        repeat (2000) step();
        bud_i = 0; bud_d = 0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
